// File: rtl/cic_pkg.sv
// Shared types and constants for the multichannel CIC decimator: FSM state
// encoding and the PDM bit to signed sample mapping.
package cic_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    OUT  = 2'd2
  } cic_state_e;

  localparam logic signed [1:0] PDM_POS = 2'sb01;
  localparam logic signed [1:0] PDM_NEG = 2'sb11;

  function automatic logic signed [1:0] pdm_to_sample(input logic bit_i);
    return bit_i ? PDM_POS : PDM_NEG;
  endfunction

endpackage

// File: rtl/multichannel_cic_decimator_if.sv
// PCM output stream of the CIC decimator: sample, channel tag, valid/ready.
interface multichannel_cic_decimator_if #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned CW    = 1
);
  logic signed [WIDTH-1:0] pcm;
  logic [CW-1:0]           channel;
  logic                    valid;
  logic                    ready;

  modport master (output pcm, output channel, output valid, input ready);
  modport slave  (input pcm, input channel, input valid, output ready);
endinterface

// File: rtl/cic_integrator.sv
// N-stage integrator cascade for a single PDM channel; wraps modulo 2^ACC_WIDTH.
module cic_integrator
  import cic_pkg::*;
#(
  parameter int unsigned ACC_WIDTH = 32,
  parameter int unsigned ORDER     = 3
) (
  input  logic                        clk_i,
  input  logic                        rst_n_i,
  input  logic                        clear_i,
  input  logic                        step_i,
  input  logic                        pdm_i,
  output logic signed [ACC_WIDTH-1:0] integ_o
);

  logic signed [ACC_WIDTH-1:0] integ_q [ORDER];
  logic signed [1:0]           smp;
  logic signed [ACC_WIDTH-1:0] x_ext;

  assign smp   = pdm_to_sample(pdm_i);
  assign x_ext = {{(ACC_WIDTH-2){smp[1]}}, smp};

  // Each stage accumulates the previous stage's registered value (pipelined cascade).
  always_ff @(posedge clk_i) begin
    if (!rst_n_i || clear_i) begin
      for (int unsigned k = 0; k < ORDER; k++) integ_q[k] <= '0;
    end else if (step_i) begin
      integ_q[0] <= integ_q[0] + x_ext;
      for (int unsigned k = 1; k < ORDER; k++) integ_q[k] <= integ_q[k] + integ_q[k-1];
    end
  end

  assign integ_o = integ_q[ORDER-1];

endmodule

// File: rtl/multichannel_cic_decimator.sv
// Multichannel PDM-to-PCM CIC decimator: per-channel integrators, one shared
// time-multiplexed comb, and a valid/ready output stream with overrun flag.
module multichannel_cic_decimator
  import cic_pkg::*;
#(
  parameter int unsigned CHANNELS     = 2,
  parameter int unsigned WIDTH        = 16,
  parameter int unsigned ACC_WIDTH    = 32,
  parameter int unsigned FILTER_ORDER = 3,
  parameter int unsigned COMB_DELAY   = 1,
  localparam int unsigned CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                    clk_i,
  input  logic                    rst_n_i,
  input  logic                    enable_i,
  input  logic [15:0]             decimation_factor_i,
  input  logic [5:0]              shift_i,
  input  logic [CHANNELS-1:0]     pdm_i,
  input  logic                    valid_i,
  output logic signed [WIDTH-1:0] pcm_o,
  output logic [CW-1:0]           channel_o,
  output logic                    valid_o,
  input  logic                    ready_i,
  output logic                    overrun_o,
  output logic                    config_error_o
);

  localparam int unsigned MIN_ACC = FILTER_ORDER * $clog2(65535 * COMB_DELAY) + 1;
  localparam logic [CW-1:0] LAST_CH = CW'(CHANNELS - 1);
  localparam logic signed [ACC_WIDTH-1:0] PCM_MAX = {{(ACC_WIDTH-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH-1:0] PCM_MIN = {{(ACC_WIDTH-WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};

  if (ACC_WIDTH < MIN_ACC) begin : g_acc_width_short
    $info("ACC_WIDTH %0d is below %0d; results rely on modulo wrap", ACC_WIDTH, MIN_ACC);
  end

  cic_state_e                  state_q, state_d;
  logic [CW-1:0]               ch_q, ch_d, chan_q;
  logic [15:0]                 cnt_q, cnt_d;
  logic                        cfg_err, strobe, tick, capture, ovr_q;
  logic signed [ACC_WIDTH-1:0] integ_w  [CHANNELS];
  logic signed [ACC_WIDTH-1:0] snap_q   [CHANNELS];
  logic signed [ACC_WIDTH-1:0] dly_q    [CHANNELS][FILTER_ORDER][COMB_DELAY];
  logic signed [ACC_WIDTH-1:0] stage_in [FILTER_ORDER];
  logic signed [ACC_WIDTH-1:0] comb_acc, shifted;
  logic signed [WIDTH-1:0]     pcm_q, pcm_d;

  for (genvar g = 0; g < CHANNELS; g++) begin : g_integ
    cic_integrator #(
      .ACC_WIDTH (ACC_WIDTH),
      .ORDER     (FILTER_ORDER)
    ) u_integ (
      .clk_i   (clk_i),
      .rst_n_i (rst_n_i),
      .clear_i (!enable_i),
      .step_i  (strobe),
      .pdm_i   (pdm_i[g]),
      .integ_o (integ_w[g])
    );
  end

  assign cfg_err = (decimation_factor_i < 16'd2);
  assign strobe  = valid_i && enable_i;
  // Equality compare: lowering D below the current count lets the counter run to 2^16 wrap.
  assign tick    = strobe && !cfg_err && (cnt_q == decimation_factor_i - 16'd1);
  assign cnt_d   = !strobe ? cnt_q : (tick ? '0 : cnt_q + 16'd1);

  always_comb begin
    comb_acc = snap_q[ch_q];
    for (int unsigned s = 0; s < FILTER_ORDER; s++) begin
      stage_in[s] = comb_acc;
      comb_acc    = comb_acc - dly_q[ch_q][s][COMB_DELAY-1];
    end
    shifted = comb_acc >>> shift_i;
    if (shifted > PCM_MAX)      pcm_d = PCM_MAX[WIDTH-1:0];
    else if (shifted < PCM_MIN) pcm_d = PCM_MIN[WIDTH-1:0];
    else                        pcm_d = shifted[WIDTH-1:0];
  end

  always_comb begin
    state_d = state_q;
    ch_d    = ch_q;
    capture = 1'b0;
    case (state_q)
      IDLE: if (tick) begin
        state_d = CALC;
        ch_d    = '0;
        capture = 1'b1;
      end
      CALC: state_d = OUT;
      OUT: if (ready_i) begin
        if (ch_q == LAST_CH) begin
          state_d = IDLE;
        end else begin
          state_d = CALC;
          ch_d    = ch_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i || !enable_i) begin
      state_q <= IDLE;
      ch_q    <= '0;
      cnt_q   <= '0;
      for (int unsigned c = 0; c < CHANNELS; c++) begin
        snap_q[c] <= '0;
        for (int unsigned s = 0; s < FILTER_ORDER; s++)
          for (int unsigned m = 0; m < COMB_DELAY; m++) dly_q[c][s][m] <= '0;
      end
    end else begin
      state_q <= state_d;
      ch_q    <= ch_d;
      cnt_q   <= cnt_d;
      if (capture) begin
        for (int unsigned c = 0; c < CHANNELS; c++) snap_q[c] <= integ_w[c];
      end
      if (state_q == CALC) begin
        for (int unsigned s = 0; s < FILTER_ORDER; s++) begin
          dly_q[ch_q][s][0] <= stage_in[s];
          for (int unsigned m = 1; m < COMB_DELAY; m++) dly_q[ch_q][s][m] <= dly_q[ch_q][s][m-1];
        end
      end
    end
  end

  // Output registers survive enable_i=0; only reset clears them.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      pcm_q  <= '0;
      chan_q <= '0;
    end else if (enable_i && state_q == CALC) begin
      pcm_q  <= pcm_d;
      chan_q <= ch_q;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i)                   ovr_q <= 1'b0;
    else if (tick && state_q != IDLE) ovr_q <= 1'b1;
  end

  assign pcm_o          = pcm_q;
  assign channel_o      = chan_q;
  assign valid_o        = (state_q == OUT);
  assign overrun_o      = ovr_q;
  assign config_error_o = cfg_err;

endmodule

// File: tb/tb_multichannel_cic_decimator.sv
// Self-checking bench for multichannel_cic_decimator: behavioural CIC model
// (cumulative sums, binomial comb) plus directed steady-state checks.
module tb_multichannel_cic_decimator;

  localparam int CH = 2;
  localparam int W  = 16;
  localparam int N  = 3;
  localparam int M  = 1;
  localparam int CW = 1;

  logic          clk = 1'b0;
  logic          rst_n, enable, valid_in;
  logic [15:0]   dfac;
  logic [5:0]    shift;
  logic [CH-1:0] pdm;
  logic          ovr, cfg_err;

  always #5 clk = ~clk;

  multichannel_cic_decimator_if #(.WIDTH(W), .CW(CW)) bus ();

  multichannel_cic_decimator #(
    .CHANNELS(CH), .WIDTH(W), .ACC_WIDTH(32), .FILTER_ORDER(N), .COMB_DELAY(M)
  ) dut (
    .clk_i(clk), .rst_n_i(rst_n), .enable_i(enable), .decimation_factor_i(dfac),
    .shift_i(shift), .pdm_i(pdm), .valid_i(valid_in), .pcm_o(bus.pcm),
    .channel_o(bus.channel), .valid_o(bus.valid), .ready_i(bus.ready),
    .overrun_o(ovr), .config_error_o(cfg_err)
  );

  int vectors = 0;
  int miscompares = 0;

  // Reference model state
  int integ [CH][N];
  int hist  [CH][N*M+1];
  int frame [CH];
  logic [15:0] m_cnt;
  bit m_busy, m_phase, m_ovr;
  int m_chan;
  logic signed [W-1:0] m_pcm;
  logic signed [W-1:0] last_pcm [CH];

  function automatic int binom(int n, int k);
    int r = 1;
    for (int i = 1; i <= k; i++) r = r * (n - k + i) / i;
    return r;
  endfunction

  function automatic logic signed [W-1:0] sat(int y, int sh);
    longint v = longint'(y) >>> sh;
    if (v > 32767)  return 16'sd32767;
    if (v < -32768) return -16'sd32768;
    return W'(v);
  endfunction

  task automatic model_clear();
    for (int c = 0; c < CH; c++) begin
      for (int k = 0; k < N; k++) integ[c][k] = 0;
      for (int i = 0; i <= N*M; i++) hist[c][i] = 0;
      frame[c] = 0;
    end
    m_cnt = 0; m_busy = 0; m_phase = 0; m_chan = 0;
  endtask

  task automatic model_step();
    bit tick, busy_pre;
    int old [N];
    if (!rst_n) begin
      model_clear();
      m_ovr = 0;
      m_pcm = 0;
    end else if (!enable) begin
      model_clear();
    end else begin
      tick     = valid_in && dfac >= 2 && m_cnt == dfac - 16'd1;
      busy_pre = m_busy;
      if (m_busy) begin
        if (!m_phase) begin
          m_phase = 1;
          m_pcm   = sat(frame[m_chan], int'(shift));
        end else if (bus.ready) begin
          if (m_chan == CH - 1) m_busy = 0;
          else begin m_chan++; m_phase = 0; end
        end
      end
      if (tick) begin
        if (busy_pre) m_ovr = 1;
        else begin
          for (int c = 0; c < CH; c++) begin
            for (int i = N*M; i > 0; i--) hist[c][i] = hist[c][i-1];
            hist[c][0] = integ[c][N-1];
            frame[c] = 0;
            for (int i = 0; i <= N; i++)
              frame[c] += ((i % 2) ? -1 : 1) * binom(N, i) * hist[c][i*M];
          end
          m_busy = 1; m_phase = 0; m_chan = 0;
        end
      end
      if (valid_in) begin
        m_cnt = tick ? 16'd0 : m_cnt + 16'd1;
        for (int c = 0; c < CH; c++) begin
          for (int k = 0; k < N; k++) old[k] = integ[c][k];
          integ[c][0] = old[0] + (pdm[c] ? 1 : -1);
          for (int k = 1; k < N; k++) integ[c][k] = old[k] + old[k-1];
        end
      end
    end
  endtask

  task automatic clk_step();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic do_reset(input logic [15:0] d);
    rst_n = 0; enable = 1; valid_in = 0; bus.ready = 1; dfac = d; shift = 0; pdm = '0;
    clk_step(); clk_step();
    rst_n = 1;
  endtask

  task automatic test_reset();
    do_reset(16'd8);
    pdm = '1; valid_in = 1; bus.ready = 0;
    for (int i = 0; i < 20; i++) clk_step();
    rst_n = 0;
    clk_step();
    vectors++; if (bus.valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid got %b want 0", bus.valid); end
    vectors++; if (bus.pcm !== 16'sd0) begin miscompares++; $display("FAIL reset_pcm got %0d want 0", bus.pcm); end
    vectors++; if (bus.channel !== 1'b0) begin miscompares++; $display("FAIL reset_channel got %0d want 0", bus.channel); end
    vectors++; if (ovr !== 1'b0) begin miscompares++; $display("FAIL reset_overrun got %b want 0", ovr); end
    rst_n = 1;
  endtask

  task automatic test_steady(input string name, input logic [15:0] d, input int pattern,
                             input int cycles, input logic signed [W-1:0] want);
    for (int c = 0; c < CH; c++) last_pcm[c] = 'x;
    for (int i = 0; i < cycles; i++) begin
      valid_in = 1;
      pdm = (pattern == 1) ? '1 : (pattern == 0) ? '0 : ((i % 2) ? '1 : '0);
      dfac = d;
      clk_step();
      vectors++;
      if (bus.valid !== (m_busy && m_phase) || ovr !== m_ovr ||
          (bus.valid && (bus.pcm !== m_pcm || bus.channel !== CW'(m_chan)))) begin
        miscompares++;
        $display("FAIL %s_cycle%0d valid=%b/%b pcm=%0d/%0d ch=%0d/%0d ovr=%b/%b", name, i,
                 bus.valid, m_busy && m_phase, bus.pcm, m_pcm, bus.channel, m_chan, ovr, m_ovr);
      end
      if (bus.valid) last_pcm[bus.channel] = bus.pcm;
    end
    for (int c = 0; c < CH; c++) begin
      vectors++;
      if (last_pcm[c] !== want) begin
        miscompares++;
        $display("FAIL %s_steady_ch%0d got %0d want %0d", name, c, last_pcm[c], want);
      end
    end
  endtask

  task automatic test_patterns();
    do_reset(16'd8);
    test_steady("ones_d8", 16'd8, 1, 120, 16'sd512);
    do_reset(16'd8);
    test_steady("zeros_d8", 16'd8, 0, 120, -16'sd512);
    do_reset(16'd8);
    test_steady("alt_d8", 16'd8, 2, 120, 16'sd0);
  endtask

  task automatic test_saturation();
    do_reset(16'd64);
    test_steady("sat_sh0", 16'd64, 1, 500, 16'sd32767);
    shift = 6'd3;
    test_steady("sat_sh3", 16'd64, 1, 200, 16'sd32767);
    shift = 6'd4;
    test_steady("sat_sh4", 16'd64, 1, 200, 16'sd16384);
  endtask

  task automatic test_back_to_back();
    do_reset(16'd8);
    pdm = '1; valid_in = 1; bus.ready = 0;
    for (int i = 0; i < 30; i++) begin
      clk_step();
      vectors++;
      if (bus.valid !== (m_busy && m_phase) || ovr !== m_ovr ||
          (bus.valid && (bus.pcm !== m_pcm || bus.channel !== CW'(m_chan)))) begin
        miscompares++;
        $display("FAIL stall_cycle%0d valid=%b/%b pcm=%0d/%0d ch=%0d/%0d ovr=%b/%b", i,
                 bus.valid, m_busy && m_phase, bus.pcm, m_pcm, bus.channel, m_chan, ovr, m_ovr);
      end
    end
    vectors++; if (bus.valid !== 1'b1) begin miscompares++; $display("FAIL stall_valid got %b want 1", bus.valid); end
    vectors++; if (bus.channel !== 1'b0) begin miscompares++; $display("FAIL stall_channel got %0d want 0", bus.channel); end
    vectors++; if (ovr !== 1'b1) begin miscompares++; $display("FAIL stall_overrun got %b want 1", ovr); end
    bus.ready = 1;
    for (int i = 0; i < 40; i++) clk_step();
    vectors++; if (ovr !== 1'b1) begin miscompares++; $display("FAIL overrun_sticky got %b want 1", ovr); end
  endtask

  task automatic test_config_error();
    do_reset(16'd1);
    pdm = '1; valid_in = 1;
    for (int i = 0; i < 40; i++) begin
      dfac = (i < 20) ? 16'd1 : 16'd0;
      clk_step();
      vectors++;
      if (bus.valid !== 1'b0 || cfg_err !== 1'b1) begin
        miscompares++;
        $display("FAIL cfgerr_cycle%0d valid=%b want 0 config_error=%b want 1", i, bus.valid, cfg_err);
      end
    end
    dfac = 16'd2;
    #1;
    vectors++; if (cfg_err !== 1'b0) begin miscompares++; $display("FAIL cfgerr_d2 got %b want 0", cfg_err); end
  endtask

  task automatic test_enable_drop();
    do_reset(16'd8);
    pdm = '1; valid_in = 1; bus.ready = 0;
    for (int i = 0; i < 12; i++) clk_step();
    vectors++; if (bus.valid !== 1'b1) begin miscompares++; $display("FAIL en_in_out got %b want 1", bus.valid); end
    enable = 0;
    clk_step();
    vectors++; if (bus.valid !== 1'b0) begin miscompares++; $display("FAIL en_drop_valid got %b want 0", bus.valid); end
    vectors++; if (ovr !== m_ovr) begin miscompares++; $display("FAIL en_drop_overrun got %b want %b", ovr, m_ovr); end
    enable = 1; bus.ready = 1;
    test_steady("reenable", 16'd8, 1, 120, 16'sd512);
  endtask

  task automatic test_random();
    do_reset(16'($urandom_range(2, 10)));
    shift = 6'($urandom_range(0, 12));
    for (int i = 0; i < 1500; i++) begin
      pdm       = CH'($urandom);
      valid_in  = ($urandom_range(0, 99) < 75);
      bus.ready = ($urandom_range(0, 99) < 60);
      enable    = ($urandom_range(0, 99) >= 2);
      clk_step();
      vectors++;
      if (bus.valid !== (m_busy && m_phase) || ovr !== m_ovr ||
          (bus.valid && (bus.pcm !== m_pcm || bus.channel !== CW'(m_chan)))) begin
        miscompares++;
        $display("FAIL random_cycle%0d valid=%b/%b pcm=%0d/%0d ch=%0d/%0d ovr=%b/%b", i,
                 bus.valid, m_busy && m_phase, bus.pcm, m_pcm, bus.channel, m_chan, ovr, m_ovr);
      end
    end
  endtask

  initial begin
    rst_n = 0; enable = 0; valid_in = 0; dfac = 16'd8; shift = 0; pdm = '0; bus.ready = 1;
    model_clear();
    m_ovr = 0; m_pcm = 0;
    test_reset();
    test_patterns();
    test_saturation();
    test_back_to_back();
    test_config_error();
    test_enable_drop();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
